// File: rtl/bus_arbiter_4_pkg.sv
// Shared definitions for the 4-input round-robin bus arbiter.
// Holds the FSM state encoding, the requester count and a one-hot helper.
package bus_arbiter_4_pkg;

    localparam int NrOfRequesters = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    function automatic logic [NrOfRequesters-1:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_4_rr_pick.sv
// rr_pick_4: combinational round-robin winner selection.
// Scans last_owner_i+1, +2, +3, +4 (mod 4) and returns the first requester set.
// Ports:
//   req_i        [3:0]  request vector
//   last_owner_i [1:0]  most recent owner; it has the lowest priority
//   winner_o     [1:0]  selected requester (0 when valid_o is low)
//   valid_o             at least one request is set
module rr_pick_4
    import bus_arbiter_4_pkg::*;
(
    input  logic [NrOfRequesters-1:0] req_i,
    input  logic [1:0]                last_owner_i,
    output logic [1:0]                winner_o,
    output logic                      valid_o
);

    logic [1:0] idx;

    // Walk from the farthest to the nearest candidate so the nearest set bit
    // is written last and wins.
    always_comb begin
        winner_o = 2'd0;
        valid_o  = 1'b0;
        idx      = 2'd0;
        for (int i = NrOfRequesters; i >= 1; i--) begin
            idx = last_owner_i + 2'(i);
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: round-robin arbiter and sequencer for a shared 4:1 bus mux.
// Grants one requester at a time, drives the mux select/enable directly and
// bounds contested tenures with a hold counter. A one-cycle GAP separates
// consecutive tenures.
//
// state | meaning
// IDLE  | no owner, arbitrating every cycle
// OWN   | owner holds the bus, mux enabled
// GAP   | dead cycle after a release, arbitrating with updated last owner
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i     [3:0]      level requests, held until ownership ends
//   done_i               owner's last bus cycle (single-cycle pulse)
//   lock_i               blocks a hold-timer release while high
//   grant_o   [3:0]      one-hot grant, registered
//   sel_o     [1:0]      mux select, registered, holds when not in OWN
//   enable_o             mux enable, registered, high only in OWN
//   busy_o               high in OWN and GAP
//   timeout_o            one-cycle pulse in GAP after a forced release
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int MaxHold = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NrOfRequesters-1:0] req_i,
    input  logic                      done_i,
    input  logic                      lock_i,
    output logic [NrOfRequesters-1:0] grant_o,
    output logic [1:0]                sel_o,
    output logic                      enable_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    arb_state_e                state_q;
    logic [1:0]                owner_q;
    logic [1:0]                last_owner_q;
    logic [7:0]                hold_cnt_q;
    logic [NrOfRequesters-1:0] grant_q;
    logic [1:0]                sel_q;
    logic                      enable_q;
    logic                      busy_q;
    logic                      timeout_q;

    logic [1:0] pick_winner;
    logic       pick_valid;
    logic       contested;
    logic       hold_expired;
    logic       force_release;
    logic       normal_release;

    rr_pick_4 u_pick (
        .req_i        (req_i),
        .last_owner_i (last_owner_q),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    // ">=" rather than "==" so a Lock held past the limit still releases
    // as soon as it drops; the counter keeps running while locked.
    assign contested      = |(req_i & ~to_onehot(owner_q));
    assign hold_expired   = hold_cnt_q >= 8'(MaxHold - 1);
    assign force_release  = hold_expired && !lock_i && contested;
    assign normal_release = done_i || !req_i[owner_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;
            hold_cnt_q   <= 8'd0;
            grant_q      <= '0;
            sel_q        <= 2'd0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                OWN: begin
                    if (normal_release || force_release) begin
                        state_q      <= GAP;
                        last_owner_q <= owner_q;
                        grant_q      <= '0;
                        enable_q     <= 1'b0;
                        busy_q       <= 1'b1;
                        // A normal cause in the same cycle makes the release normal.
                        timeout_q    <= force_release && !normal_release;
                    end else if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                // IDLE and GAP arbitrate identically; GAP sees the updated last owner.
                default: begin
                    if (pick_valid) begin
                        state_q    <= OWN;
                        owner_q    <= pick_winner;
                        hold_cnt_q <= 8'd0;
                        grant_q    <= to_onehot(pick_winner);
                        sel_q      <= pick_winner;
                        enable_q   <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign enable_o  = enable_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule
